apb_slave_regfile: RTL and testbench
====================================

# apb_slave_regfile

APB3 responder holding a bank of 32-bit registers, acting as the peripheral at the far end of the AHB-to-APB bridge. It decodes PADDR against a base address and completes reads and writes with a wait-state count sampled from a sideband input. Out-of-range or misaligned accesses complete with PSLVERR. The bench uses it as the reference APB target for bridge verification.

## Interface
- PADDR_SIZE, 32, APB address width
- PDATA_SIZE, 32, APB data width
- NUM_REGS, 16, number of word registers (power of two, 2..256)
- BASE_ADDR, 32'h0000_0000, byte address of register 0 (aligned to NUM_REGS*4)

Ports:
- PCLK  in  1  APB clock; all state on rising edge
- PRESETn  in  1  asynchronous active-low reset
- PSEL  in  1  slave select
- PENABLE  in  1  access-phase indicator
- PWRITE  in  1  1 = write, 0 = read
- PADDR  in  PADDR_SIZE  byte address
- PWDATA  in  PDATA_SIZE  write data
- wait_cycles  in  4  wait states for the next transfer, sampled in setup phase
- PRDATA  out  PDATA_SIZE  read data, valid when PREADY=1 in access phase
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error, valid only with PREADY=1

## Operation
- FSM states: IDLE, ACCESS. Reset -> IDLE.
- IDLE: on PSEL=1 & PENABLE=0 (setup phase), latch PWRITE, PADDR, decode result; load cnt <= wait_cycles; PREADY <= (wait_cycles==0); go ACCESS.
- ACCESS, PREADY=0: cnt <= cnt-1; PREADY <= (cnt==1).
- ACCESS, PREADY=1 (with PSEL=PENABLE=1): transfer completes; write commits at this edge when no error; PREADY <= 0, PSLVERR <= 0; go IDLE.
- Decode: off = PADDR - BASE_ADDR; error if PADDR[1:0] != 0 or off >= NUM_REGS*4; index = off[ $clog2(NUM_REGS)+1 : 2 ].
- PRDATA/PSLVERR registered with the PREADY rise: read -> PRDATA = reg[index] (0 on error); write -> PRDATA = 0. PSLVERR = error flag.
- Error write: no register updated. Error read: PRDATA = 0.
- Abort: PSEL=0 while in ACCESS -> go IDLE, no write, PREADY/PSLVERR <= 0.
- Setup phase with PENABLE=1 seen in IDLE is ignored (stays IDLE).

## Timing
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, all registers 0, cnt=0.
- Setup at cycle T, wait_cycles=N: PREADY high in cycle T+1+N; write visible to a read started in the following transfer.
- Back-to-back: completion edge returns to IDLE; a new setup phase in the very next cycle is accepted (2-cycle minimum transfer when N=0).
- wait_cycles changes during ACCESS have no effect on the current transfer.
- Reset asserted mid-transfer: immediate return to reset values; pending write discarded.

## Configuration
- APB_SLV_WAIT_EN defined: wait-state counter and wait_cycles input behave as above.
- Undefined: wait_cycles ignored, counter removed; PREADY <= 1 at every accepted setup phase (zero-wait, 2-cycle transfers). Port list unchanged.

## Test plan
- Reset: hold PRESETn=0 3 cycles -> PRDATA=0, PREADY=0, PSLVERR=0; read of 0x0 returns 0.
- Zero-wait write 0xDEADBEEF to 0x8, then read 0x8 -> PREADY high 1 cycle after setup each time, PRDATA=0xDEADBEEF, PSLVERR=0.
- wait_cycles=3, read 0x4 -> PREADY low 3 access cycles, high on 4th; wait_cycles changed to 0 mid-access has no effect.
- Write 0x12345678 to 0x40 (NUM_REGS=16) and to 0x2 -> PSLVERR=1 with PREADY, no register changed; read of 0x40 -> PRDATA=0, PSLVERR=1.
- Back-to-back write 0x4 / read 0x4 with no idle cycle -> read returns new data, 4 cycles total at N=0.
- PSEL dropped in ACCESS with wait_cycles=5 on a write -> FSM to IDLE, target register unchanged; PRESETn pulsed mid-access -> all outputs 0 next cycle.

Source files
------------

// File: rtl/apb_slave_regfile_if.sv
// APB3 bus bundle between a requester and apb_slave_regfile, plus the wait-state sideband.
interface apb_slave_regfile_if #(
  parameter int unsigned PADDR_SIZE = 32,
  parameter int unsigned PDATA_SIZE = 32
);
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [PADDR_SIZE-1:0] PADDR;
  logic [PDATA_SIZE-1:0] PWDATA;
  logic [3:0]            wait_cycles;
  logic [PDATA_SIZE-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, wait_cycles,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, wait_cycles,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// APB3 register-file responder: NUM_REGS word registers at BASE_ADDR.
// Out-of-range or misaligned accesses complete with PSLVERR.
// Optional feature macro APB_SLV_WAIT_EN: wait states loaded from wait_cycles at setup.
// Without it every transfer is zero-wait and wait_cycles is ignored.
module apb_slave_regfile #(
  parameter int unsigned          PADDR_SIZE = 32,
  parameter int unsigned          PDATA_SIZE = 32,
  parameter int unsigned          NUM_REGS   = 16,
  parameter logic [PADDR_SIZE-1:0] BASE_ADDR = '0
) (
  input logic               PCLK,
  input logic               PRESETn,
  apb_slave_regfile_if.slave apb
);

  localparam int unsigned           IdxW      = $clog2(NUM_REGS);
  localparam logic [PADDR_SIZE-1:0] SpanBytes = PADDR_SIZE'(NUM_REGS * 4);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e                r_state;
  logic                  r_write;
  logic                  r_err;
  logic [IdxW-1:0]       r_idx;
  logic [PDATA_SIZE-1:0] r_regs [NUM_REGS];
  logic [PDATA_SIZE-1:0] r_prdata;
  logic                  r_pready;
  logic                  r_pslverr;

  logic [PADDR_SIZE-1:0] w_off;
  logic                  w_err;
  logic [IdxW-1:0]       w_idx;
  logic                  w_setup;
  logic                  w_zero_wait;
  logic [PDATA_SIZE-1:0] w_rd_setup;
  logic [PDATA_SIZE-1:0] w_rd_access;

`ifdef APB_SLV_WAIT_EN
  logic [3:0] r_cnt;
  assign w_zero_wait = (apb.wait_cycles == 4'd0);
`else
  logic w_unused_wait;
  assign w_unused_wait = ^apb.wait_cycles;
  assign w_zero_wait   = 1'b1;
`endif

  // Address decode; an address below BASE_ADDR wraps to a huge offset and so reads as out of range.
  always_comb begin
    w_off = apb.PADDR - BASE_ADDR;
    w_err = (apb.PADDR[1:0] != 2'b00) || (w_off >= SpanBytes);
    w_idx = w_off[IdxW+1:2];
  end

  // Read data for the two points where PREADY can rise: straight from setup, or after the wait.
  always_comb begin
    w_setup     = apb.PSEL & ~apb.PENABLE;
    w_rd_setup  = (apb.PWRITE || w_err) ? '0 : r_regs[w_idx];
    w_rd_access = (r_write || r_err) ? '0 : r_regs[r_idx];
  end

  // Transfer FSM with registered PREADY/PRDATA/PSLVERR and the register bank itself.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= StIdle;
      r_write   <= 1'b0;
      r_err     <= 1'b0;
      r_idx     <= '0;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
`ifdef APB_SLV_WAIT_EN
      r_cnt     <= 4'd0;
`endif
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      case (r_state)
        StIdle: begin
          // PENABLE already high here is not a valid setup phase and is ignored.
          if (w_setup) begin
            r_write  <= apb.PWRITE;
            r_idx    <= w_idx;
            r_err    <= w_err;
            r_pready <= w_zero_wait;
`ifdef APB_SLV_WAIT_EN
            r_cnt    <= apb.wait_cycles;
`endif
            if (w_zero_wait) begin
              r_prdata  <= w_rd_setup;
              r_pslverr <= w_err;
            end
            r_state <= StAccess;
          end
        end
        StAccess: begin
          if (!apb.PSEL) begin
            // Requester abandoned the transfer: nothing commits.
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_state   <= StIdle;
          end else if (r_pready) begin
            if (apb.PENABLE) begin
              if (r_write && !r_err) begin
                r_regs[r_idx] <= apb.PWDATA;
              end
              r_pready  <= 1'b0;
              r_pslverr <= 1'b0;
              r_state   <= StIdle;
            end
          end else begin
`ifdef APB_SLV_WAIT_EN
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
              r_pready  <= 1'b1;
              r_prdata  <= w_rd_access;
              r_pslverr <= r_err;
            end
`endif
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign apb.PRDATA  = r_prdata;
  assign apb.PREADY  = r_pready;
  assign apb.PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Directed bench for apb_slave_regfile: a vector table of single transfers plus hand-written
// sequences for back-to-back, abort and mid-transfer reset.
module tb_apb_slave_regfile;

`ifdef APB_SLV_WAIT_EN
  localparam bit WaitEn = 1'b1;
`else
  localparam bit WaitEn = 1'b0;
`endif

  logic PCLK;
  logic PRESETn;
  int   checks;
  int   errors;
  int   cyc;

  apb_slave_regfile_if #(.PADDR_SIZE(32), .PDATA_SIZE(32)) bus ();

  apb_slave_regfile #(
    .PADDR_SIZE(32),
    .PDATA_SIZE(32),
    .NUM_REGS  (16),
    .BASE_ADDR (32'h0000_0000)
  ) dut (
    .PCLK   (PCLK),
    .PRESETn(PRESETn),
    .apb    (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  always @(posedge PCLK) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wc;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [14];

  function automatic int exp_lat(input logic [3:0] w);
    return WaitEn ? int'(w) : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One full transfer; wait_cycles is changed to 0 after setup to prove it has no effect.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wc, output logic [31:0] rdata, output logic err,
                      output int lat);
    bus.PSEL        = 1'b1;
    bus.PENABLE     = 1'b0;
    bus.PWRITE      = wr;
    bus.PADDR       = addr;
    bus.PWDATA      = wdata;
    bus.wait_cycles = wc;
    @(posedge PCLK); #1;
    bus.PENABLE     = 1'b1;
    bus.wait_cycles = 4'd0;
    lat = 0;
    while (bus.PREADY !== 1'b1 && lat < 40) begin
      @(posedge PCLK); #1;
      lat++;
    end
    rdata = bus.PRDATA;
    err   = bus.PSLVERR;
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          c0;

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'd0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'd0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0,         4'd0, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0004, 32'hA5A5_0001, 4'd2, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         4'd3, 32'hA5A5_0001, 1'b0};
    vecs[5]  = '{1'b1, 32'h0000_0040, 32'h1234_5678, 4'd0, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 32'h0000_0002, 32'h1234_5678, 4'd1, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 32'h0000_0040, 32'h0,         4'd0, 32'h0,         1'b1};
    vecs[8]  = '{1'b0, 32'h0000_0008, 32'h0,         4'd0, 32'hDEAD_BEEF, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         4'd0, 32'h0,         1'b0};
    vecs[10] = '{1'b1, 32'h0000_003C, 32'hCAFE_F00D, 4'd1, 32'h0,         1'b0};
    vecs[11] = '{1'b0, 32'h0000_003C, 32'h0,         4'd0, 32'hCAFE_F00D, 1'b0};
    vecs[12] = '{1'b0, 32'h0000_003D, 32'h0,         4'd2, 32'h0,         1'b1};
    vecs[13] = '{1'b0, 32'hFFFF_FFFC, 32'h0,         4'd0, 32'h0,         1'b1};

    bus.PSEL        = 1'b0;
    bus.PENABLE     = 1'b0;
    bus.PWRITE      = 1'b0;
    bus.PADDR       = '0;
    bus.PWDATA      = '0;
    bus.wait_cycles = '0;

    // Reset held for three cycles.
    PRESETn = 1'b0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset PRDATA", bus.PRDATA, 32'h0);
    chk("reset PREADY", 32'(bus.PREADY), 32'h0);
    chk("reset PSLVERR", 32'(bus.PSLVERR), 32'h0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Table of single transfers, issued back to back.
    for (int i = 0; i < 14; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wc, rd, er, lat);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
      chk($sformatf("vec%0d pslverr", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d wait", i), 32'(lat), 32'(exp_lat(vecs[i].wc)));
    end

    // Back-to-back zero-wait write then read of the same register: four cycles total.
    @(posedge PCLK); #1;
    c0 = cyc;
    xfer(1'b1, 32'h4, 32'h1111_2222, 4'd0, rd, er, lat);
    xfer(1'b0, 32'h4, 32'h0, 4'd0, rd, er, lat);
    chk("b2b rdata", rd, 32'h1111_2222);
    chk("b2b cycles", 32'(cyc - c0), 32'd4);

    // Abort: PSEL dropped during the access phase of a write.
    bus.PSEL        = 1'b1;
    bus.PENABLE     = 1'b0;
    bus.PWRITE      = 1'b1;
    bus.PADDR       = 32'hC;
    bus.PWDATA      = 32'h0000_0055;
    bus.wait_cycles = 4'd5;
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("abort PREADY", 32'(bus.PREADY), 32'h0);
    chk("abort PSLVERR", 32'(bus.PSLVERR), 32'h0);
    xfer(1'b0, 32'hC, 32'h0, 4'd0, rd, er, lat);
    chk("abort reg unchanged", rd, 32'h0);

    // Reset pulsed during the first access cycle of a write.
    bus.PSEL        = 1'b1;
    bus.PENABLE     = 1'b0;
    bus.PWRITE      = 1'b1;
    bus.PADDR       = 32'h10;
    bus.PWDATA      = 32'h0000_0077;
    bus.wait_cycles = 4'd5;
    @(posedge PCLK); #1;
    bus.PENABLE = 1'b1;
    #2;
    PRESETn = 1'b0;
    #1;
    chk("midreset PREADY", 32'(bus.PREADY), 32'h0);
    chk("midreset PSLVERR", 32'(bus.PSLVERR), 32'h0);
    chk("midreset PRDATA", bus.PRDATA, 32'h0);
    @(posedge PCLK); #1;
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    PRESETn     = 1'b1;
    @(posedge PCLK); #1;
    chk("postreset PREADY", 32'(bus.PREADY), 32'h0);
    xfer(1'b0, 32'h10, 32'h0, 4'd0, rd, er, lat);
    chk("postreset pending write dropped", rd, 32'h0);
    xfer(1'b0, 32'h8, 32'h0, 4'd0, rd, er, lat);
    chk("postreset regs cleared", rd, 32'h0);
    chk("postreset read pslverr", 32'(er), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
